tlb_op_seq: RTL and testbench

TLB_OP_SEQ -- requirements
Module: tlb_op_seq

---
 rtl/tlb_pkg.sv | 28 ++
 rtl/tlb_match.sv | 16 +
 rtl/tlb_op_seq.sv | 183 ++++++++++++++++++
 tb/tb_tlb_op_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB definitions: op codes, sequencer state encoding, entry count and EntryHi/EntryLo field positions.
package tlb_pkg;
  localparam int TLB_ENTRIES = 16;
  localparam int IDX_W       = 4;

  localparam int VPN2_MSB = 31;
  localparam int VPN2_LSB = 13;
  localparam int VPN2_W   = VPN2_MSB - VPN2_LSB + 1;
  localparam int ASID_MSB = 7;
  localparam int ASID_LSB = 0;
  localparam int ASID_W   = ASID_MSB - ASID_LSB + 1;
  localparam int G_BIT    = 0;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'b00,
    OP_TLBR  = 2'b01,
    OP_TLBWI = 2'b10,
    OP_TLBWR = 2'b11
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } tlb_state_e;
endpackage

// File: rtl/tlb_match.sv
// Combinational TLB entry compare: VPN2 must match, and ASID must match unless the entry is global.
module tlb_match
  import tlb_pkg::*;
(
  input  logic [VPN2_W-1:0] ent_vpn2_i,
  input  logic [ASID_W-1:0] ent_asid_i,
  input  logic              ent_g0_i,
  input  logic              ent_g1_i,
  input  logic [VPN2_W-1:0] key_vpn2_i,
  input  logic [ASID_W-1:0] key_asid_i,
  output logic              match_o
);
  // An entry is global only when both halves of the pair carry G.
  assign match_o = (ent_vpn2_i == key_vpn2_i) &&
                   ((ent_asid_i == key_asid_i) || (ent_g0_i && ent_g1_i));
endmodule

// File: rtl/tlb_op_seq.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR against the TLB array, stalling the pipeline until the op completes.
module tlb_op_seq
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = tlb_pkg::TLB_ENTRIES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid_i,
  input  logic [1:0]       op_code_i,
  output logic             op_ready_o,
  output logic             busy_o,
  output logic             done_o,
  input  logic [31:0]      cp0_index_i,
  input  logic [31:0]      cp0_random_i,
  input  logic [31:0]      cp0_entryhi_i,
  input  logic [31:0]      cp0_entrylo0_i,
  input  logic [31:0]      cp0_entrylo1_i,
  output logic [IDX_W-1:0] tlb_addr_o,
  output logic             tlb_we_o,
  output logic [31:0]      tlb_whi_o,
  output logic [31:0]      tlb_wlo0_o,
  output logic [31:0]      tlb_wlo1_o,
  input  logic [31:0]      tlb_rhi_i,
  input  logic [31:0]      tlb_rlo0_i,
  input  logic [31:0]      tlb_rlo1_i,
  output logic [31:0]      entryhi_o,
  output logic [31:0]      entrylo0_o,
  output logic [31:0]      entrylo1_o,
  output logic             entryhi_wen_o,
  output logic             entrylo0_wen_o,
  output logic             entrylo1_wen_o,
  output logic             probe_success_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_wen_o
);
  localparam int CNT_W = $clog2(TLB_ENTRIES) + 1;

  tlb_state_e       state_q, state_d;
  tlb_op_e          op_q, op_d;
  logic [31:0]      hi_q, hi_d, lo0_q, lo0_d, lo1_q, lo1_d;
  logic [IDX_W-1:0] index_q, index_d, random_q, random_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic [CNT_W-1:0] cmp_idx;
  logic             match;
  logic             unused_bits;

  assign unused_bits = ^{cp0_index_i[31:IDX_W], cp0_random_i[31:IDX_W]};

  // Read data lags the address by a cycle, so the entry under compare is cnt_q-1.
  assign cmp_idx = cnt_q - CNT_W'(1);

  tlb_match u_match (
    .ent_vpn2_i (tlb_rhi_i[VPN2_MSB:VPN2_LSB]),
    .ent_asid_i (tlb_rhi_i[ASID_MSB:ASID_LSB]),
    .ent_g0_i   (tlb_rlo0_i[G_BIT]),
    .ent_g1_i   (tlb_rlo1_i[G_BIT]),
    .key_vpn2_i (hi_q[VPN2_MSB:VPN2_LSB]),
    .key_asid_i (hi_q[ASID_MSB:ASID_LSB]),
    .match_o    (match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_TLBP;
      hi_q      <= '0;
      lo0_q     <= '0;
      lo1_q     <= '0;
      index_q   <= '0;
      random_q  <= '0;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo0_q     <= lo0_d;
      lo1_q     <= lo1_d;
      index_q   <= index_d;
      random_q  <= random_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    hi_d            = hi_q;
    lo0_d           = lo0_q;
    lo1_d           = lo1_q;
    index_d         = index_q;
    random_d        = random_q;
    cnt_d           = cnt_q;
    hit_d           = hit_q;
    hit_idx_d       = hit_idx_q;
    op_ready_o      = 1'b0;
    busy_o          = 1'b1;
    done_o          = 1'b0;
    tlb_addr_o      = '0;
    tlb_we_o        = 1'b0;
    tlb_whi_o       = '0;
    tlb_wlo0_o      = '0;
    tlb_wlo1_o      = '0;
    entryhi_o       = '0;
    entrylo0_o      = '0;
    entrylo1_o      = '0;
    entryhi_wen_o   = 1'b0;
    entrylo0_wen_o  = 1'b0;
    entrylo1_wen_o  = 1'b0;
    probe_success_o = 1'b0;
    idx_o           = '0;
    idx_wen_o       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        op_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (op_valid_i) begin
          op_d      = tlb_op_e'(op_code_i);
          hi_d      = cp0_entryhi_i;
          lo0_d     = cp0_entrylo0_i;
          lo1_d     = cp0_entrylo1_i;
          index_d   = cp0_index_i[IDX_W-1:0];
          random_d  = cp0_random_i[IDX_W-1:0];
          cnt_d     = '0;
          hit_d     = 1'b0;
          hit_idx_d = '0;
          case (tlb_op_e'(op_code_i))
            OP_TLBP: state_d = ST_PROBE;
            OP_TLBR: state_d = ST_READ;
            default: state_d = ST_WRITE;
          endcase
        end
      end
      ST_PROBE: begin
        tlb_addr_o = cnt_q[IDX_W-1:0];
        cnt_d      = cnt_q + CNT_W'(1);
        if ((cnt_q != '0) && match) begin
          hit_d     = 1'b1;
          hit_idx_d = cmp_idx[IDX_W-1:0];
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_W'(TLB_ENTRIES)) begin
          state_d = ST_DONE;
        end
      end
      ST_READ: begin
        tlb_addr_o = index_q;
        state_d    = ST_DONE;
      end
      ST_WRITE: begin
        tlb_addr_o = (op_q == OP_TLBWR) ? random_q : index_q;
        tlb_we_o   = 1'b1;
        tlb_whi_o  = hi_q;
        tlb_wlo0_o = lo0_q;
        tlb_wlo1_o = lo1_q;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
        if (op_q == OP_TLBP) begin
          probe_success_o = hit_q;
          idx_o           = hit_idx_q;
          idx_wen_o       = hit_q;
        end else if (op_q == OP_TLBR) begin
          entryhi_o      = tlb_rhi_i;
          entrylo0_o     = tlb_rlo0_i;
          entrylo1_o     = tlb_rlo1_i;
          entryhi_wen_o  = 1'b1;
          entrylo0_wen_o = 1'b1;
          entrylo1_wen_o = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_tlb_op_seq.sv
// Directed bench for tlb_op_seq with a one-cycle-latency TLB array model.
module tb_tlb_op_seq;
  import tlb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid_i = 1'b0;
  logic [1:0]  op_code_i = 2'b00;
  logic        op_ready_o, busy_o, done_o;
  logic [31:0] cp0_index_i = '0, cp0_random_i = '0, cp0_entryhi_i = '0;
  logic [31:0] cp0_entrylo0_i = '0, cp0_entrylo1_i = '0;
  logic [3:0]  tlb_addr_o;
  logic        tlb_we_o;
  logic [31:0] tlb_whi_o, tlb_wlo0_o, tlb_wlo1_o;
  logic [31:0] tlb_rhi_i, tlb_rlo0_i, tlb_rlo1_i;
  logic [31:0] entryhi_o, entrylo0_o, entrylo1_o;
  logic        entryhi_wen_o, entrylo0_wen_o, entrylo1_wen_o;
  logic        probe_success_o, idx_wen_o;
  logic [3:0]  idx_o;

  logic [31:0] mem_hi [16];
  logic [31:0] mem_lo0[16];
  logic [31:0] mem_lo1[16];
  int          wr_cnt = 0, done_cnt = 0;
  logic [3:0]  wr_addr = '0;
  int          errors = 0, checks = 0;
  int          lat, wr0, d0;

  localparam logic [31:0] KEY = {19'h2AAAA, 5'd0, 8'h33};

  always #5 clk = ~clk;

  tlb_op_seq dut (
    .clk(clk), .reset(reset),
    .op_valid_i(op_valid_i), .op_code_i(op_code_i), .op_ready_o(op_ready_o),
    .busy_o(busy_o), .done_o(done_o),
    .cp0_index_i(cp0_index_i), .cp0_random_i(cp0_random_i), .cp0_entryhi_i(cp0_entryhi_i),
    .cp0_entrylo0_i(cp0_entrylo0_i), .cp0_entrylo1_i(cp0_entrylo1_i),
    .tlb_addr_o(tlb_addr_o), .tlb_we_o(tlb_we_o),
    .tlb_whi_o(tlb_whi_o), .tlb_wlo0_o(tlb_wlo0_o), .tlb_wlo1_o(tlb_wlo1_o),
    .tlb_rhi_i(tlb_rhi_i), .tlb_rlo0_i(tlb_rlo0_i), .tlb_rlo1_i(tlb_rlo1_i),
    .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
    .entryhi_wen_o(entryhi_wen_o), .entrylo0_wen_o(entrylo0_wen_o), .entrylo1_wen_o(entrylo1_wen_o),
    .probe_success_o(probe_success_o), .idx_o(idx_o), .idx_wen_o(idx_wen_o)
  );

  // Array model: registered read, write activity only logged.
  always @(posedge clk) begin
    tlb_rhi_i  <= mem_hi[tlb_addr_o];
    tlb_rlo0_i <= mem_lo0[tlb_addr_o];
    tlb_rlo1_i <= mem_lo1[tlb_addr_o];
    if (tlb_we_o) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = tlb_addr_o;
    end
    if (done_o) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 16; i++) begin
      mem_hi[i]  = {19'h10000 + 19'(i), 5'd0, 8'h40 + 8'(i)};
      mem_lo0[i] = '0;
      mem_lo1[i] = '0;
    end
  endtask

  task automatic start(input logic [1:0] code);
    op_valid_i = 1'b1;
    op_code_i  = code;
    check("ready_at_T", 32'(op_ready_o), 32'd1);
    step();
    op_valid_i = 1'b0;
  endtask

  task automatic probe(input string tag, input int exp_lat, input logic exp_hit, input logic [3:0] exp_idx);
    int n;
    cp0_entryhi_i = KEY;
    start(OP_TLBP);
    n = 1;
    while (!done_o && n < 40) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_succ"}, 32'(probe_success_o), 32'(exp_hit));
    check({tag, "_idxwen"}, 32'(idx_wen_o), 32'(exp_hit));
    if (exp_hit) check({tag, "_idx"}, 32'(idx_o), 32'(exp_idx));
    step();
  endtask

  initial begin
    init_mem();
    step();
    step();
    check("rst_ready", 32'(op_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_we", 32'(tlb_we_o), 32'd0);
    check("rst_addr", 32'(tlb_addr_o), 32'd0);
    check("rst_idx", 32'(idx_o), 32'd0);
    check("rst_wens", 32'({entryhi_wen_o, entrylo0_wen_o, entrylo1_wen_o, idx_wen_o, probe_success_o}), 32'd0);
    check("rst_whi", tlb_whi_o, 32'd0);
    reset = 1'b0;
    step();

    // TLBWI to index 5; inputs change after acceptance
    cp0_index_i = 32'd5; cp0_entryhi_i = 32'h00402005;
    cp0_entrylo0_i = 32'h00000011; cp0_entrylo1_i = 32'h00000022;
    start(OP_TLBWI);
    cp0_index_i = 32'd7; cp0_entryhi_i = 32'hDEADBEEF; cp0_entrylo0_i = '0;
    check("wi_we", 32'(tlb_we_o), 32'd1);
    check("wi_addr", 32'(tlb_addr_o), 32'd5);
    check("wi_whi", tlb_whi_o, 32'h00402005);
    check("wi_wlo0", tlb_wlo0_o, 32'h00000011);
    check("wi_wlo1", tlb_wlo1_o, 32'h00000022);
    check("wi_busy", 32'(busy_o), 32'd1);
    check("wi_ready_T1", 32'(op_ready_o), 32'd0);
    step();
    check("wi_done", 32'(done_o), 32'd1);
    check("wi_we_T2", 32'(tlb_we_o), 32'd0);
    check("wi_wens_T2", 32'({entryhi_wen_o, idx_wen_o}), 32'd0);
    step();
    check("wi_ready_T3", 32'(op_ready_o), 32'd1);
    check("wi_done_T3", 32'(done_o), 32'd0);

    // TLBWR with random changing after acceptance
    cp0_index_i = 32'd3; cp0_random_i = 32'd9;
    start(OP_TLBWR);
    cp0_random_i = 32'd10;
    check("wr_we", 32'(tlb_we_o), 32'd1);
    check("wr_addr", 32'(tlb_addr_o), 32'd9);
    step();
    check("wr_done", 32'(done_o), 32'd1);
    check("wr_logaddr", 32'(wr_addr), 32'd9);
    step();

    // TLBR index 2
    mem_hi[2] = 32'h12346001; mem_lo0[2] = 32'hAAAA0003; mem_lo1[2] = 32'h55550005;
    cp0_index_i = 32'd2;
    wr0 = wr_cnt;
    start(OP_TLBR);
    check("rd_addr", 32'(tlb_addr_o), 32'd2);
    check("rd_we", 32'(tlb_we_o), 32'd0);
    check("rd_wen_T1", 32'(entryhi_wen_o), 32'd0);
    step();
    check("rd_done", 32'(done_o), 32'd1);
    check("rd_hi", entryhi_o, 32'h12346001);
    check("rd_lo0", entrylo0_o, 32'hAAAA0003);
    check("rd_lo1", entrylo1_o, 32'h55550005);
    check("rd_wens", 32'({entryhi_wen_o, entrylo0_wen_o, entrylo1_wen_o}), 32'd7);
    check("rd_idxwen", 32'(idx_wen_o), 32'd0);
    step();
    check("rd_nowrite", 32'(wr_cnt), 32'(wr0));

    // TLBP: entries 3 and 7 match -> first one wins
    init_mem();
    mem_hi[3] = KEY; mem_hi[7] = KEY;
    probe("p37", 6, 1'b1, 4'd3);

    // TLBP: no match anywhere
    init_mem();
    probe("pmiss", 18, 1'b0, 4'd0);

    // TLBP: entry 0 global with ASID mismatch
    mem_hi[0] = {19'h2AAAA, 5'd0, 8'h99}; mem_lo0[0] = 32'd1; mem_lo1[0] = 32'd1;
    probe("pglob", 3, 1'b1, 4'd0);

    // TLBP: G only in one half is not global; exact match at entry 4
    mem_lo1[0] = 32'd0; mem_hi[4] = KEY;
    probe("phalfg", 7, 1'b1, 4'd4);

    // TLBP: only the last entry matches
    init_mem();
    mem_hi[15] = KEY;
    probe("plast", 18, 1'b1, 4'd15);

    // Reset in the middle of a TLBP, with op_valid held during busy
    init_mem();
    cp0_entryhi_i = KEY; cp0_index_i = 32'd1;
    wr0 = wr_cnt; d0 = done_cnt;
    op_valid_i = 1'b1; op_code_i = OP_TLBP;
    step();
    op_code_i = OP_TLBWI;
    check("abort_busy_T1", 32'(busy_o), 32'd1);
    step();
    step();
    step();
    check("abort_busy_T4", 32'(busy_o), 32'd1);
    op_valid_i = 1'b0;
    reset = 1'b1;
    step();
    check("abort_ready", 32'(op_ready_o), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_idxwen", 32'(idx_wen_o), 32'd0);
    reset = 1'b0;
    step();
    step();
    check("abort_nowrite", 32'(wr_cnt), 32'(wr0));
    check("abort_nodone", 32'(done_cnt), 32'(d0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
